// File: rtl/bank_ctrl.sv
// bank_ctrl: serial-command sequencer driving a two-port bank SRAM (port A read, port B write)
module bank_ctrl #(
  parameter int WIDTH  = 128,
  parameter int AW     = 7,
  parameter int RD_LAT = 1
) (
  input  logic             vsi_clk,
  input  logic             vsi_reset,
  input  logic             vsi_inputData,
  input  logic             vsi_chipSelect,
  output logic             vsi_outputData,
  output logic             busy,
  output logic             sram_cen_a,
  output logic [AW-1:0]    sram_aA,
  output logic             sram_cen_b,
  output logic [AW-1:0]    sram_aB,
  output logic [WIDTH-1:0] sram_d,
  output logic [WIDTH-1:0] sram_bw,
  input  logic [WIDTH-1:0] sram_q
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int CW = (BW > AW + 1) ? BW : AW + 1;
  typedef enum logic [3:0] {IDLE, HDR, WDAT, WR, FILL, RD, RWAIT, SHO, ENDW} state_t;
  state_t           r_state, w_nxt;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [AW+1:0]    r_hdr, w_hdr;
  logic [WIDTH-1:0] r_dat, w_dat;
  logic             r_out;
  logic [1:0]       w_op;
  logic [AW-1:0]    w_addr;
  logic             w_wr;
  assign w_op   = r_hdr[AW+1:AW];
  assign w_addr = r_hdr[AW-1:0];
  assign w_wr   = (r_state == WR) || (r_state == FILL);
  // r_dat holds write data and doubles as the read-back shift register
  always_comb begin
    w_nxt = r_state;
    w_cnt = r_cnt;
    w_hdr = r_hdr;
    w_dat = r_dat;
    case (r_state)
      IDLE: if (vsi_chipSelect) begin
        w_hdr = {r_hdr[AW:0], vsi_inputData};
        w_cnt = CW'(1);
        w_nxt = HDR;
      end
      HDR: if (!vsi_chipSelect) begin
        w_nxt = IDLE;
        w_cnt = '0;
      end else begin
        w_hdr = {r_hdr[AW:0], vsi_inputData};
        w_cnt = r_cnt + CW'(1);
        if (r_cnt == CW'(AW + 1)) begin
          w_cnt = '0;
          w_nxt = (w_hdr[AW+1:AW] == 2'b00) ? ENDW : (w_hdr[AW+1:AW] == 2'b10) ? RD : WDAT;
        end
      end
      WDAT: if (!vsi_chipSelect) begin
        w_nxt = IDLE;
        w_cnt = '0;
      end else begin
        w_dat = {r_dat[WIDTH-2:0], vsi_inputData};
        w_cnt = r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_cnt = '0;
          w_nxt = (w_op == 2'b11) ? FILL : WR;
        end
      end
      WR: w_nxt = ENDW;
      FILL: begin
        w_cnt = r_cnt + CW'(1);
        if (r_cnt == CW'((1 << AW) - 1)) begin
          w_cnt = '0;
          w_nxt = ENDW;
        end
      end
      RD: w_nxt = RWAIT;
      RWAIT: begin
        w_cnt = r_cnt + CW'(1);
        if (r_cnt == CW'(RD_LAT - 1)) begin
          w_cnt = '0;
          w_dat = sram_q;
          w_nxt = SHO;
        end
      end
      SHO: if (!vsi_chipSelect) begin
        w_nxt = IDLE;
        w_cnt = '0;
      end else begin
        w_dat = {r_dat[WIDTH-2:0], 1'b0};
        w_cnt = r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_cnt = '0;
          w_nxt = ENDW;
        end
      end
      ENDW: w_nxt = vsi_chipSelect ? ENDW : IDLE;
      default: begin
        w_nxt = IDLE;
        w_cnt = '0;
      end
    endcase
  end
  always_ff @(posedge vsi_clk or posedge vsi_reset) begin
    if (vsi_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hdr   <= '0;
      r_dat   <= '0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt;
      r_hdr   <= w_hdr;
      r_dat   <= w_dat;
      r_out   <= (w_nxt == SHO) && w_dat[WIDTH-1];
    end
  end
  assign vsi_outputData = r_out;
  assign busy           = r_state != IDLE;
  assign sram_cen_a     = r_state != RD;
  assign sram_aA        = (r_state == RD) ? w_addr : '0;
  assign sram_cen_b     = !w_wr;
  assign sram_aB        = (r_state == FILL) ? r_cnt[AW-1:0] : (r_state == WR) ? w_addr : '0;
  assign sram_d         = w_wr ? r_dat : '0;
  assign sram_bw        = {WIDTH{w_wr}};
endmodule
